// File: rtl/decereal_if.sv
// decereal_if: serial line in, received byte plus status out, with the valid/ack handshake.
interface decereal_if;
    logic       cereal_in;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;
    modport slave (
        input  cereal_in, ack,
        output data, valid, frame_err, parity_err, overrun, busy
    );
    modport master (
        output cereal_in, ack,
        input  data, valid, frame_err, parity_err, overrun, busy
    );
endinterface

// File: rtl/decereal.sv
// decereal: mid-bit sampling serial receiver with framing/parity/overrun flags.
// Define DECEREAL_PARITY_EN to add an even-parity bit before the stop bit.
module decereal #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic       sysclk,
    input logic       reset,
    decereal_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef DECEREAL_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;
    state_t        r_state;
    logic          r_s1, r_s2;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid, r_frame_err, r_parity_err, r_overrun, r_busy;
    logic          w_tick;
    assign w_tick = r_cnt == BIT_M1;
    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = r_busy;
`ifdef DECEREAL_PARITY_EN
    logic r_perr;
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_s1         <= 1'b1;
            r_s2         <= 1'b1;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shreg      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef DECEREAL_PARITY_EN
            r_perr       <= 1'b0;
`endif
        end else begin
            r_s1 <= bus.cereal_in;
            r_s2 <= r_s1;
            if (r_valid && bus.ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            case (r_state)
                IDLE: if (!r_s2) begin
                    r_state <= START;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                START: if (r_cnt == HALF_M1) begin
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    r_state <= r_s2 ? IDLE : DATA;
                    r_busy  <= ~r_s2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DATA: if (w_tick) begin
                    r_cnt   <= '0;
                    r_shreg <= {r_s2, r_shreg[7:1]};
                    r_bit   <= r_bit + 1'b1;
`ifdef DECEREAL_PARITY_EN
                    if (r_bit == 3'd7) r_state <= PARITY;
`else
                    if (r_bit == 3'd7) r_state <= STOP;
`endif
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
`ifdef DECEREAL_PARITY_EN
                PARITY: if (w_tick) begin
                    r_cnt   <= '0;
                    r_perr  <= r_s2 ^ (^r_shreg);
                    r_state <= STOP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
`endif
                // Commit wins over a same-edge ack: valid stays set, overrun follows ack.
                STOP: if (w_tick) begin
                    r_cnt       <= '0;
                    r_data      <= r_shreg;
                    r_frame_err <= ~r_s2;
`ifdef DECEREAL_PARITY_EN
                    r_parity_err <= r_perr;
`endif
                    r_valid     <= 1'b1;
                    r_overrun   <= r_valid ? ~bus.ack : r_overrun;
                    r_busy      <= 1'b0;
                    r_state     <= r_s2 ? IDLE : WAIT_HIGH;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                WAIT_HIGH: if (r_s2) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decereal.sv
// tb_decereal: directed vector table plus hand-written glitch, break, overrun and reset sequences.
module tb_decereal;
    localparam int CPB = 16;
`ifdef DECEREAL_PARITY_EN
    localparam bit PE = 1'b1;
    localparam int LAT = 170;
`else
    localparam bit PE = 1'b0;
    localparam int LAT = 154;
`endif
    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    int rise_cyc = 0;
    int e0 = 0;
    bit pv = 1'b0;
    bit busy_seen = 1'b0;
    decereal_if bus();
    decereal #(.CLKS_PER_BIT(CPB)) dut (.sysclk(sysclk), .reset(reset), .bus(bus));
    always #5 sysclk = ~sysclk;
    always begin
        @(posedge sysclk);
        cyc++;
        #1;
        if (bus.valid && !pv) begin
            rises++;
            rise_cyc = cyc;
        end
        pv = bus.valid;
        if (bus.busy) busy_seen = 1'b1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic drive_bit(input logic b);
        bus.cereal_in = b;
        repeat (CPB) @(negedge sysclk);
    endtask
    // Leaves the line at the stop-bit level; caller restores idle if needed.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        @(negedge sysclk);
        e0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PE) drive_bit((^d) ^ pflip);
        drive_bit(stop);
    endtask
    task automatic do_ack();
        @(negedge sysclk);
        bus.ack = 1'b1;
        @(negedge sysclk);
        bus.ack = 1'b0;
    endtask
    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       pflip;
        logic       fe;
        logic       pe;
    } vec_t;
    vec_t v[8];
    initial begin
        int r0;
        v[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
        v[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        v[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, PE};
        v[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
        v[5] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
        v[6] = '{8'h07, 1'b1, 1'b1, 1'b0, PE};
        v[7] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.cereal_in = 1'b1;
        bus.ack = 1'b0;
        #1;
        chk("reset_outputs", {bus.data, bus.valid, bus.frame_err, bus.parity_err, bus.overrun, bus.busy}, 32'h0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            r0 = rises;
            send_frame(v[i].d, v[i].stop, v[i].pflip);
            bus.cereal_in = 1'b1;
            chk($sformatf("v%0d_commit", i), rises - r0, 1);
            chk($sformatf("v%0d_latency", i), rise_cyc - e0, LAT);
            chk($sformatf("v%0d_data", i), bus.data, v[i].d);
            chk($sformatf("v%0d_valid", i), bus.valid, 1);
            chk($sformatf("v%0d_frame_err", i), bus.frame_err, v[i].fe);
            chk($sformatf("v%0d_parity_err", i), bus.parity_err, v[i].pe);
            do_ack();
            chk($sformatf("v%0d_ack_valid", i), bus.valid, 0);
            chk($sformatf("v%0d_hold_data", i), bus.data, v[i].d);
            repeat (2 * CPB) @(negedge sysclk);
        end
        // Glitch: 5-cycle low pulse is a false start.
        r0 = rises;
        busy_seen = 1'b0;
        @(negedge sysclk);
        bus.cereal_in = 1'b0;
        repeat (5) @(negedge sysclk);
        bus.cereal_in = 1'b1;
        repeat (30) @(negedge sysclk);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_low", bus.busy, 0);
        chk("glitch_no_valid", rises - r0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("post_glitch_data", bus.data, 8'h3C);
        chk("post_glitch_commit", rises - r0, 1);
        do_ack();
        // Break: stop=0 then line held low for 40 bit times.
        repeat (2 * CPB) @(negedge sysclk);
        r0 = rises;
        send_frame(8'h55, 1'b0, 1'b0);
        chk("break_data", bus.data, 8'h55);
        chk("break_frame_err", bus.frame_err, 1);
        do_ack();
        repeat (40 * CPB) @(negedge sysclk);
        chk("break_single_commit", rises - r0, 1);
        chk("break_valid_low", bus.valid, 0);
        chk("break_busy_low", bus.busy, 0);
        bus.cereal_in = 1'b1;
        repeat (3 * CPB) @(negedge sysclk);
        chk("break_still_single", rises - r0, 1);
        send_frame(8'hC3, 1'b1, 1'b0);
        chk("after_break_data", bus.data, 8'hC3);
        chk("after_break_fe", bus.frame_err, 0);
        do_ack();
        // Overrun: two back-to-back frames without ack.
        repeat (2 * CPB) @(negedge sysclk);
        send_frame(8'h11, 1'b1, 1'b0);
        chk("ovr_first_clear", bus.overrun, 0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_data", bus.data, 8'h22);
        chk("ovr_valid", bus.valid, 1);
        chk("ovr_flag", bus.overrun, 1);
        do_ack();
        chk("ovr_ack_valid", bus.valid, 0);
        chk("ovr_ack_flag", bus.overrun, 0);
        // Reset in the middle of data bit 4 of 0xFF.
        repeat (2 * CPB) @(negedge sysclk);
        r0 = rises;
        bus.cereal_in = 1'b0;
        repeat (CPB) @(negedge sysclk);
        bus.cereal_in = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge sysclk);
        reset = 1'b1;
        #1;
        chk("midreset_outputs", {bus.data, bus.valid, bus.frame_err, bus.parity_err, bus.overrun, bus.busy}, 32'h0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (6 * CPB) @(negedge sysclk);
        chk("midreset_no_commit", rises - r0, 0);
        chk("midreset_idle", bus.busy, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        chk("postreset_commit", rises - r0, 1);
        chk("postreset_data", bus.data, 8'h81);
        chk("postreset_fe", bus.frame_err, 0);
        do_ack();
        repeat (4) @(negedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
